// File: rtl/tile_judge_if.sv
// Tile feed into the judge and the judged game status coming back out.
// The tile source is the master; the rule engine is the slave.
interface tile_judge_if;
    logic [1:0] tile_lane;
    logic       tile_new;
    logic [1:0] game_state;
    logic [9:0] score;
    logic       hit_pulse;
    logic       miss_pulse;

    modport master (
        output tile_lane,
        output tile_new,
        input  game_state,
        input  score,
        input  hit_pulse,
        input  miss_pulse
    );

    modport slave (
        input  tile_lane,
        input  tile_new,
        output game_state,
        output score,
        output hit_pulse,
        output miss_pulse
    );
endinterface

// File: rtl/tile_judge.sv
// Piano Tiles rule engine: button conditioning, IDLE/PLAY/OVER control,
// press judging against the hit-row tile and saturating score.
module tile_judge #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TILE_WINDOW     = 25000000,
    parameter int SCORE_MAX       = 999
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         button_1,
    input  logic         button_2,
    input  logic         button_3,
    input  logic         button_4,
    input  logic         start_button,
    tile_judge_if.slave  tj
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WW = $clog2(TILE_WINDOW + 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(TILE_WINDOW - 1);
    localparam logic [9:0]    SMAX     = 10'(SCORE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    logic [4:0] raw, sync1, sync2, press;

    assign raw = {start_button, button_4, button_3, button_2, button_1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_db
        logic [CW-1:0] cnt;
        logic          level;
        logic          evt;

        // Only an accepted rising level produces an event; release is silent.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt   <= '0;
                level <= 1'b0;
                evt   <= 1'b0;
            end else begin
                evt <= 1'b0;
                if (sync2[i] == level) begin
                    cnt <= '0;
                end else if (cnt == DB_LAST) begin
                    cnt   <= '0;
                    level <= sync2[i];
                    evt   <= sync2[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign press[i] = evt;
    end

    logic [3:0] lanes;
    logic       start, multi, single;
    logic [1:0] lane;

    assign lanes  = press[3:0];
    assign start  = press[4];
    assign multi  = |(lanes & (lanes - 4'd1));
    assign single = (|lanes) && !multi;

    always_comb begin
        case (lanes)
            4'b0010: lane = 2'd1;
            4'b0100: lane = 2'd2;
            4'b1000: lane = 2'd3;
            default: lane = 2'd0;
        endcase
    end

    state_t        state_q, state_d;
    logic [9:0]    score_q, score_d;
    logic          pend_q, pend_d;
    logic [1:0]    plane_q, plane_d;
    logic [WW-1:0] win_q, win_d;
    logic          hit_q, hit_d;
    logic          miss_q, miss_d;

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        pend_d  = pend_q;
        plane_d = plane_q;
        win_d   = win_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d = PLAY;
                    score_d = '0;
                    pend_d  = 1'b0;
                    win_d   = '0;
                end
            end
            PLAY: begin
                if (tj.tile_new && pend_q) begin
                    miss_d = 1'b1;
                end else if (multi) begin
                    miss_d = 1'b1;
                end else if (single && pend_q && lane == plane_q) begin
                    hit_d  = 1'b1;
                    pend_d = 1'b0;
                    win_d  = '0;
                end else if (single && !pend_q) begin
                    // No tile waiting: only a tile arriving this cycle can match.
                    if (tj.tile_new && lane == tj.tile_lane)
                        hit_d = 1'b1;
                    else
                        miss_d = 1'b1;
                end else if (single) begin
                    miss_d = 1'b1;
                end else if (pend_q && win_q == WIN_LAST) begin
                    miss_d = 1'b1;
                end else if (tj.tile_new) begin
                    pend_d  = 1'b1;
                    plane_d = tj.tile_lane;
                    win_d   = '0;
                end else if (pend_q) begin
                    win_d = win_q + 1'b1;
                end
                if (hit_d && score_q != SMAX)
                    score_d = score_q + 10'd1;
                if (miss_d)
                    state_d = OVER;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            score_q <= '0;
            pend_q  <= 1'b0;
            plane_q <= 2'd0;
            win_q   <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            pend_q  <= pend_d;
            plane_q <= plane_d;
            win_q   <= win_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    assign tj.game_state = state_q;
    assign tj.score      = score_q;
    assign tj.hit_pulse  = hit_q;
    assign tj.miss_pulse = miss_q;
endmodule

// File: tb/tb_tile_judge.sv
// Directed bench for tile_judge: stimulus queues expected pulses,
// a negedge monitor pops and compares each hit/miss the DUT presents.
module tb_tile_judge;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic button_1 = 1'b0;
    logic button_2 = 1'b0;
    logic button_3 = 1'b0;
    logic button_4 = 1'b0;
    logic start_button = 1'b0;

    tile_judge_if tj ();

    tile_judge #(
        .DEBOUNCE_CYCLES(4),
        .TILE_WINDOW    (20),
        .SCORE_MAX      (999)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button_1    (button_1),
        .button_2    (button_2),
        .button_3    (button_3),
        .button_4    (button_4),
        .start_button(start_button),
        .tj          (tj)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       hit;
        logic [9:0] score;
        logic [1:0] state;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic hit, input int score, input int state);
        exp_t e;
        e.hit   = hit;
        e.score = 10'(score);
        e.state = 2'(state);
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst && (tj.hit_pulse || tj.miss_pulse)) begin
            check("pulse_exclusive", int'(tj.hit_pulse & tj.miss_pulse), 0);
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: hit=%0d miss=%0d score=%0d, none expected",
                         tj.hit_pulse, tj.miss_pulse, tj.score);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse_kind_hit", int'(tj.hit_pulse), int'(e.hit));
                check("pulse_score", int'(tj.score), int'(e.score));
                check("pulse_state", int'(tj.game_state), int'(e.state));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        {button_4, button_3, button_2, button_1} = m;
        repeat (hold) tick();
        {button_4, button_3, button_2, button_1} = 4'b0000;
        repeat (8) tick();
    endtask

    task automatic new_tile(input int lane);
        tj.tile_lane = 2'(lane);
        tj.tile_new  = 1'b1;
        tick();
        tj.tile_new  = 1'b0;
    endtask

    task automatic start_game();
        start_button = 1'b1;
        repeat (10) tick();
        start_button = 1'b0;
        repeat (8) tick();
        check("restart_state", int'(tj.game_state), 1);
        check("restart_score", int'(tj.score), 0);
    endtask

    initial begin
        tj.tile_lane = 2'd0;
        tj.tile_new  = 1'b0;
        #2;
        check("reset_state", int'(tj.game_state), 0);
        check("reset_score", int'(tj.score), 0);
        check("reset_hit", int'(tj.hit_pulse), 0);
        check("reset_miss", int'(tj.miss_pulse), 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();

        // start press: PLAY within 8 cycles
        start_button = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (tj.game_state == 2'd1) break;
        end
        check("start_within_8", int'(tj.game_state), 1);
        check("start_score", int'(tj.score), 0);
        repeat (2) tick();
        start_button = 1'b0;
        repeat (8) tick();

        // correct hit on lane 2 (button_3)
        new_tile(2);
        expect_ev(1'b1, 1, 1);
        press(4'b0100, 10);
        check("hit_score", int'(tj.score), 1);
        check("hit_state", int'(tj.game_state), 1);

        // wrong lane ends the game, later presses ignored
        new_tile(0);
        expect_ev(1'b0, 1, 2);
        press(4'b1000, 8);
        check("wrong_state", int'(tj.game_state), 2);
        press(4'b0001, 8);
        press(4'b0010, 8);
        check("over_score_frozen", int'(tj.score), 1);
        check("over_state_held", int'(tj.game_state), 2);

        // window timeout on cycle 20
        start_game();
        new_tile(1);
        repeat (19) tick();
        check("window_not_yet", int'(tj.game_state), 1);
        expect_ev(1'b0, 0, 2);
        tick();
        check("window_expired", int'(tj.game_state), 2);
        repeat (3) tick();

        // second tile while one is pending
        start_game();
        new_tile(1);
        repeat (4) tick();
        expect_ev(1'b0, 0, 2);
        new_tile(3);
        check("double_tile_state", int'(tj.game_state), 2);
        repeat (3) tick();

        // glitches rejected, then a real hit, then a two-lane press
        start_game();
        new_tile(0);
        for (int r = 0; r < 2; r++) begin
            button_1 = 1'b1;
            repeat (2) tick();
            button_1 = 1'b0;
            repeat (3) tick();
        end
        check("glitch_state", int'(tj.game_state), 1);
        check("glitch_score", int'(tj.score), 0);
        expect_ev(1'b1, 1, 1);
        press(4'b0001, 8);
        expect_ev(1'b0, 1, 2);
        press(4'b0011, 8);
        check("multi_state", int'(tj.game_state), 2);
        check("multi_score", int'(tj.score), 1);

        // run the score up to saturation
        start_game();
        for (int k = 1; k <= 1000; k++) begin
            new_tile(k % 4);
            expect_ev(1'b1, (k > 999) ? 999 : k, 1);
            press(4'(1 << (k % 4)), 8);
            if (k == 998) check("score_998", int'(tj.score), 998);
        end
        check("score_saturated", int'(tj.score), 999);
        check("sat_state", int'(tj.game_state), 1);

        // asynchronous reset mid-game
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_state", int'(tj.game_state), 0);
        check("async_rst_score", int'(tj.score), 0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (4) tick();
        check("idle_after_rst", int'(tj.game_state), 0);
        check("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
